// File: rtl/alu_cmd_driver_pkg.sv
// Shared constants for the ALU command driver: default widths, opcodes, FSM encoding.
package alu_cmd_driver_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int OPW_DEF   = 3;
   localparam int CNTW_DEF  = 8;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NOT  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_LESS = 3'b110;
   localparam logic [2:0] OP_EQ   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   // Compare results are returned to the requester but never written back to the accumulator.
   function automatic logic op_is_compare(input logic [2:0] op);
      return (op == OP_LESS) || (op == OP_EQ);
   endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command/response handshake plus the ALU operand/result bus, seen from the driver (slave)
// and from the environment that issues commands and hosts the ALU (master).
interface alu_cmd_driver_if
   import alu_cmd_driver_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_load;
   logic [OPW-1:0]   cmd_op;
   logic [WIDTH-1:0] cmd_data;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic [WIDTH-1:0] alu_out;

   modport slave (
      input  cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready, alu_out,
      output cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op
   );

   modport master (
      output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready, alu_out,
      input  cmd_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op
   );

endinterface

// File: rtl/alu_cmd_driver.sv
// Initiator for the combinational ALU: accepts one command at a time, keeps the
// accumulator as operand A, writes results back and returns them over a response channel.
//
// state | meaning
// IDLE  | ready for a command; accepting latches operand B, opcode and load flag
// EXEC  | ALU settles on registered operands; result captured into rsp_data/acc
// RESP  | response held stable until the consumer takes it
module alu_cmd_driver
   import alu_cmd_driver_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF,
   parameter int CNTW  = CNTW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_cmd_driver_if.slave  bus,
   output logic [WIDTH-1:0] acc,
   output logic [CNTW-1:0]  cmd_cnt
);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_alu_b;
   logic [OPW-1:0]   r_op;
   logic             r_load;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_data;
   logic [CNTW-1:0]  r_cnt;

   logic             w_cmd_ready;
   logic             w_accept;
   logic             w_exec;
   logic             w_rsp_done;
   logic             w_is_cmp;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: EXEC always lasts exactly one cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (bus.cmd_valid) w_next_state = ST_EXEC;
         ST_EXEC: w_next_state = ST_RESP;
         ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State-derived strobes; cmd_ready depends on the state alone.
   always_comb begin
      w_cmd_ready = (r_state == ST_IDLE);
      w_accept    = w_cmd_ready && bus.cmd_valid;
      w_exec      = (r_state == ST_EXEC);
      w_rsp_done  = (r_state == ST_RESP) && r_rsp_valid && bus.rsp_ready;
      w_is_cmp    = op_is_compare(3'(r_op));
   end

   // Datapath: operand capture at acceptance, result write-back in EXEC, count on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_alu_b     <= '0;
         r_op        <= '0;
         r_load      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_alu_b <= bus.cmd_data;
            r_op    <= bus.cmd_op;
            r_load  <= bus.cmd_load;
            if (bus.cmd_load) r_acc <= bus.cmd_data;
         end
         if (w_exec) begin
            r_rsp_valid <= 1'b1;
            if (r_load) begin
               r_rsp_data <= r_acc;
            end else begin
               r_rsp_data <= bus.alu_out;
               if (!w_is_cmp) r_acc <= bus.alu_out;
            end
         end
         if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= r_cnt + CNTW'(1);
         end
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.alu_a     = r_acc;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_op    = r_op;
   assign acc           = r_acc;
   assign cmd_cnt       = r_cnt;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: hosts a behavioural ALU, applies a directed vector table,
// backpressure and async-reset sequences, then random commands against a reference model.
module tb_alu_cmd_driver;
   import alu_cmd_driver_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] acc;
   logic [7:0] cmd_cnt;

   int n_vec;
   int n_err;

   logic [3:0] m_acc;
   logic [7:0] m_cnt;

   alu_cmd_driver_if #(.WIDTH(4), .OPW(3)) bus ();

   alu_cmd_driver #(.WIDTH(4), .OPW(3), .CNTW(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .acc     (acc),
      .cmd_cnt (cmd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The ALU that sits beside the driver: signed less-than, everything else unsigned mod 16.
   always_comb begin
      bus.alu_out = 4'h0;
      case (bus.alu_op)
         3'd0: bus.alu_out = bus.alu_a + bus.alu_b;
         3'd1: bus.alu_out = bus.alu_a - bus.alu_b;
         3'd2: bus.alu_out = ~bus.alu_a;
         3'd3: bus.alu_out = bus.alu_a & bus.alu_b;
         3'd4: bus.alu_out = bus.alu_a | bus.alu_b;
         3'd5: bus.alu_out = bus.alu_a ^ bus.alu_b;
         3'd6: bus.alu_out = {3'b000, $signed(bus.alu_a) < $signed(bus.alu_b)};
         3'd7: bus.alu_out = {3'b000, bus.alu_a == bus.alu_b};
         default: bus.alu_out = 4'h0;
      endcase
   end

   // Reference: result and new accumulator from integer arithmetic; returns {new_acc, rsp}.
   function automatic logic [7:0] ref_exec(input logic ld, input logic [2:0] op,
                                           input logic [3:0] d, input logic [3:0] a_in);
      int a, b, sa, sb, r;
      a  = int'(a_in);
      b  = int'(d);
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      if (ld) return {d, d};
      case (int'(op))
         0: r = (a + b) % 16;
         1: r = (a - b + 16) % 16;
         2: r = 15 - a;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (sa < sb) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      if (int'(op) < 6) return {4'(r), 4'(r)};
      return {a_in, 4'(r)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one command from a negedge in IDLE, hold the response for 'hold' cycles, then take it.
   task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [3:0] d,
                          input logic [3:0] exp_a, input logic [3:0] exp_rsp,
                          input logic [3:0] exp_acc, input int hold, input string nm);
      int guard;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk({nm, "_ready_wait"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = ld;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'($urandom);
      bus.cmd_op    = 3'($urandom);
      bus.cmd_data  = 4'($urandom);
      @(negedge clk);
      chk({nm, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, "_exec_ready"}, 32'(bus.cmd_ready), 32'd0);
      chk({nm, "_alu_a"}, 32'(bus.alu_a), 32'(exp_a));
      chk({nm, "_alu_b"}, 32'(bus.alu_b), 32'(d));
      chk({nm, "_alu_op"}, 32'(bus.alu_op), 32'(op));
      @(negedge clk);
      chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_rsp));
      chk({nm, "_acc"}, 32'(acc), 32'(exp_acc));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         chk({nm, "_hold_data"}, 32'(bus.rsp_data), 32'(exp_rsp));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      m_cnt = m_cnt + 8'd1;
      @(negedge clk);
      chk({nm, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, "_done_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({nm, "_cnt"}, 32'(cmd_cnt), 32'(m_cnt));
   endtask

   task automatic pulse_reset(input string nm);
      rst_n = 1'b0;
      #1;
      chk({nm, "_rst_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({nm, "_rst_acc"}, 32'(acc), 32'd0);
      chk({nm, "_rst_cnt"}, 32'(cmd_cnt), 32'd0);
      chk({nm, "_rst_ready"}, 32'(bus.cmd_ready), 32'd1);
      chk({nm, "_rst_b"}, 32'(bus.alu_b), 32'd0);
      #1;
      rst_n = 1'b1;
      m_acc = 4'h0;
      m_cnt = 8'h00;
   endtask

   typedef struct {
      logic       ld;
      logic [2:0] op;
      logic [3:0] d;
      logic [3:0] exp_rsp;
      logic [3:0] exp_acc;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [7:0] r;
      logic [3:0] prev;
      logic       ld;
      logic [2:0] op;
      logic [3:0] d;

      n_vec = 0;
      n_err = 0;
      m_acc = 4'h0;
      m_cnt = 8'h00;

      tbl[0]  = '{1'b1, OP_ADD,  4'h3, 4'h3, 4'h3};
      tbl[1]  = '{1'b0, OP_ADD,  4'h5, 4'h8, 4'h8};
      tbl[2]  = '{1'b0, OP_ADD,  4'h9, 4'h1, 4'h1};
      tbl[3]  = '{1'b1, OP_SUB,  4'h8, 4'h8, 4'h8};
      tbl[4]  = '{1'b0, OP_SUB,  4'h9, 4'hF, 4'hF};
      tbl[5]  = '{1'b0, OP_LESS, 4'h1, 4'h1, 4'hF};
      tbl[6]  = '{1'b0, OP_EQ,   4'hF, 4'h1, 4'hF};
      tbl[7]  = '{1'b1, OP_AND,  4'hA, 4'hA, 4'hA};
      tbl[8]  = '{1'b0, OP_AND,  4'h6, 4'h2, 4'h2};
      tbl[9]  = '{1'b0, OP_OR,   4'h8, 4'hA, 4'hA};
      tbl[10] = '{1'b0, OP_XOR,  4'hF, 4'h5, 4'h5};
      tbl[11] = '{1'b0, OP_NOT,  4'h7, 4'hA, 4'hA};

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_load  = 1'b0;
      bus.cmd_op    = 3'h0;
      bus.cmd_data  = 4'h0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
      chk("reset_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_data", 32'(bus.rsp_data), 32'd0);
      chk("reset_acc", 32'(acc), 32'd0);
      chk("reset_alu_a", 32'(bus.alu_a), 32'd0);
      chk("reset_alu_b", 32'(bus.alu_b), 32'd0);
      chk("reset_alu_op", 32'(bus.alu_op), 32'd0);
      chk("reset_cnt", 32'(cmd_cnt), 32'd0);

      // Directed table.
      prev = 4'h0;
      for (int i = 0; i < 12; i++) begin
         run_cmd(tbl[i].ld, tbl[i].op, tbl[i].d, tbl[i].ld ? tbl[i].d : prev,
                 tbl[i].exp_rsp, tbl[i].exp_acc, i % 3, $sformatf("vec%0d", i));
         prev = tbl[i].exp_acc;
      end
      m_acc = prev;

      // Backpressure with a command held valid throughout.
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_data  = 4'h7;
      bus.cmd_op    = OP_ADD;
      @(posedge clk);
      #1;
      bus.cmd_load = 1'b0;
      bus.cmd_data = 4'h1;
      @(negedge clk);
      chk("bp_exec_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'h7);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_hold_data", 32'(bus.rsp_data), 32'h7);
         chk("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp_hold_acc", 32'(acc), 32'h7);
         chk("bp_hold_b", 32'(bus.alu_b), 32'h7);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      m_cnt = m_cnt + 8'd1;
      @(negedge clk);
      chk("bp_done_ready", 32'(bus.cmd_ready), 32'd1);
      chk("bp_done_valid", 32'(bus.rsp_valid), 32'd0);
      chk("bp_done_b", 32'(bus.alu_b), 32'h7);
      chk("bp_done_cnt", 32'(cmd_cnt), 32'(m_cnt));
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_next_b", 32'(bus.alu_b), 32'h1);
      chk("bp_next_a", 32'(bus.alu_a), 32'h7);
      @(negedge clk);
      chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_next_data", 32'(bus.rsp_data), 32'h8);
      chk("bp_next_acc", 32'(acc), 32'h8);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      m_cnt = m_cnt + 8'd1;
      @(negedge clk);
      chk("bp_next_cnt", 32'(cmd_cnt), 32'(m_cnt));

      // Reset while a response waits with rsp_ready low.
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_data  = 4'h5;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rr_pre_valid", 32'(bus.rsp_valid), 32'd1);
      pulse_reset("rr");
      @(negedge clk);
      chk("rr_post_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rr_post_ready", 32'(bus.cmd_ready), 32'd1);

      // Reset while in EXEC: the command in flight is dropped.
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_data  = 4'h9;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      pulse_reset("re");
      @(negedge clk);
      chk("re_post_valid", 32'(bus.rsp_valid), 32'd0);
      chk("re_post_acc", 32'(acc), 32'd0);

      // Random commands against the reference model; 260 of them wraps the counter.
      for (int i = 0; i < 260; i++) begin
         ld = ($urandom_range(0, 3) == 0);
         op = 3'($urandom);
         d  = 4'($urandom);
         r  = ref_exec(ld, op, d, m_acc);
         repeat ($urandom_range(0, 2)) begin
            bus.cmd_load = 1'($urandom);
            bus.cmd_op   = 3'($urandom);
            bus.cmd_data = 4'($urandom);
            @(negedge clk);
         end
         run_cmd(ld, op, d, ld ? d : m_acc, r[3:0], r[7:4],
                 int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
         m_acc = r[7:4];
         if (i == 255) chk("cnt_wrap", 32'(cmd_cnt), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
